// File: rtl/jogo_memoria_pkg.sv
// Shared types and helpers for the parametrised memory game: state codes,
// sequence-content rule and level-to-round-target mapping.
package jogo_memoria_pkg;

    typedef enum logic [3:0] {
        INICIAL     = 4'd0,
        PREPARA     = 4'd1,
        MOSTRA      = 4'd2,
        PAUSA       = 4'd3,
        ESPERA      = 4'd4,
        REGISTRA    = 4'd5,
        COMPARA     = 4'd6,
        PROX_JOGADA = 4'd7,
        PROX_RODADA = 4'd8,
        GANHOU      = 4'd9,
        PERDEU      = 4'd10,
        TIMEOUT     = 4'd11
    } estado_t;

    // Index of the lit button for bank b, address a.
    function automatic int seq_indice(input int endereco, input int banco, input int n_botoes);
        return (endereco * (banco + 1) + banco) % n_botoes;
    endfunction

    function automatic int alvo_rodadas(input logic nivel, input int prof);
        return nivel ? prof : prof / 2;
    endfunction

    function automatic int largura_banco(input int n_bancos);
        return (n_bancos > 1) ? $clog2(n_bancos) : 1;
    endfunction

endpackage

// File: rtl/jogo_memoria_parametrizado_if.sv
// Player-side bundle of the memory game: buttons, controls, LEDs, flags and
// debug taps. master = board/bench side, slave = game core.
interface jogo_memoria_parametrizado_if
    import jogo_memoria_pkg::*;
#(
    parameter int N_BOTOES = 4,
    parameter int PROF     = 16,
    parameter int N_BANCOS = 2
);
    localparam int MW = largura_banco(N_BANCOS);
    localparam int RW = $clog2(PROF);

    logic                jogar;
    logic [N_BOTOES-1:0] botoes;
    logic                nivel;
    logic [MW-1:0]       memoria;
    logic [N_BOTOES-1:0] leds;
    logic                ganhou;
    logic                perdeu;
    logic                timeout;
    logic                pronto;
    logic [3:0]          db_estado;
    logic [RW-1:0]       db_rodada;
    logic [RW-1:0]       db_endereco;

    modport master (
        output jogar, botoes, nivel, memoria,
        input  leds, ganhou, perdeu, timeout, pronto, db_estado, db_rodada, db_endereco
    );

    modport slave (
        input  jogar, botoes, nivel, memoria,
        output leds, ganhou, perdeu, timeout, pronto, db_estado, db_rodada, db_endereco
    );

endinterface

// File: rtl/banco_sequencias.sv
// Combinational sequence ROM: (bank, address) -> one-hot button word.
// Contents are elaboration-time constants, so this folds to a small mux tree.
module banco_sequencias
    import jogo_memoria_pkg::*;
#(
    parameter int N_BOTOES = 4,
    parameter int PROF     = 16,
    parameter int N_BANCOS = 2,
    localparam int MW      = largura_banco(N_BANCOS),
    localparam int RW      = $clog2(PROF)
)(
    input  logic [MW-1:0]       banco,
    input  logic [RW-1:0]       endereco,
    output logic [N_BOTOES-1:0] palavra
);
    localparam logic [N_BOTOES-1:0] UM = N_BOTOES'(1);

    logic [N_BOTOES-1:0] tabela [N_BANCOS][PROF];

    genvar gb, gi;
    generate
        for (gb = 0; gb < N_BANCOS; gb++) begin : g_banco
            for (gi = 0; gi < PROF; gi++) begin : g_endereco
                assign tabela[gb][gi] = UM << seq_indice(gi, gb, N_BOTOES);
            end
        end
    endgenerate

    always_comb begin
        palavra = '0;
        for (int b = 0; b < N_BANCOS; b++) begin
            if (banco == MW'(b)) begin
                palavra = tabela[b][endereco];
            end
        end
    end

endmodule

// File: rtl/jogo_memoria_parametrizado.sv
// Memory game core: LED playback, press capture with edge detection, compare,
// round/step counters and one shared timer for LED, pause and idle timeout.
module jogo_memoria_parametrizado
    import jogo_memoria_pkg::*;
#(
    parameter int N_BOTOES  = 4,
    parameter int PROF      = 16,
    parameter int N_BANCOS  = 2,
    parameter int T_LED     = 500,
    parameter int T_PAUSA   = 250,
    parameter int T_TIMEOUT = 3000
)(
    input  logic clock,
    input  logic reset,
    jogo_memoria_parametrizado_if.slave bus
);
    localparam int MW    = largura_banco(N_BANCOS);
    localparam int RW    = $clog2(PROF);
    localparam int T_MAX = (T_LED > T_PAUSA)
                         ? ((T_LED > T_TIMEOUT) ? T_LED : T_TIMEOUT)
                         : ((T_PAUSA > T_TIMEOUT) ? T_PAUSA : T_TIMEOUT);
    localparam int TW    = $clog2(T_MAX + 1);

    estado_t             estado_q,     estado_d;
    logic [RW-1:0]       rodada_q,     rodada_d;
    logic [RW-1:0]       endereco_q,   endereco_d;
    logic [TW-1:0]       timer_q,      timer_d;
    logic [MW-1:0]       banco_q,      banco_d;
    logic                nivel_q,      nivel_d;
    logic [N_BOTOES-1:0] jogada_q,     jogada_d;
    logic [N_BOTOES-1:0] botoes_q,     botoes_d;
    logic [N_BOTOES-1:0] botoes_ant_q, botoes_ant_d;

    logic [N_BOTOES-1:0] palavra_seq;
    logic [RW-1:0]       ultima_rodada;
    logic                pressionou;
    logic                acertou;

    banco_sequencias #(
        .N_BOTOES (N_BOTOES),
        .PROF     (PROF),
        .N_BANCOS (N_BANCOS)
    ) u_banco (
        .banco    (banco_q),
        .endereco (endereco_q),
        .palavra  (palavra_seq)
    );

    // A press is the first registered sample that is non-zero after an all-zero one.
    assign pressionou    = (botoes_q != '0) && (botoes_ant_q == '0);
    assign acertou       = (jogada_q == palavra_seq) && $onehot(jogada_q);
    assign ultima_rodada = RW'(alvo_rodadas(nivel_q, PROF) - 1);

    always_comb begin
        estado_d     = estado_q;
        rodada_d     = rodada_q;
        endereco_d   = endereco_q;
        timer_d      = timer_q;
        banco_d      = banco_q;
        nivel_d      = nivel_q;
        jogada_d     = jogada_q;
        botoes_d     = bus.botoes;
        botoes_ant_d = botoes_q;

        unique case (estado_q)
            INICIAL, GANHOU, PERDEU, TIMEOUT: begin
                if (bus.jogar) begin
                    estado_d = PREPARA;
                end
            end

            PREPARA: begin
                nivel_d    = bus.nivel;
                banco_d    = (int'(bus.memoria) < N_BANCOS) ? bus.memoria : '0;
                rodada_d   = '0;
                endereco_d = '0;
                timer_d    = '0;
                estado_d   = MOSTRA;
            end

            MOSTRA: begin
                if (timer_q == TW'(T_LED - 1)) begin
                    timer_d  = '0;
                    estado_d = PAUSA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            PAUSA: begin
                if (timer_q == TW'(T_PAUSA - 1)) begin
                    timer_d = '0;
                    if (endereco_q == rodada_q) begin
                        endereco_d = '0;
                        estado_d   = ESPERA;
                    end else begin
                        endereco_d = endereco_q + RW'(1);
                        estado_d   = MOSTRA;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            // Press beats expiry when both land on the same cycle.
            ESPERA: begin
                if (pressionou) begin
                    jogada_d = botoes_q;
                    timer_d  = '0;
                    estado_d = REGISTRA;
                end else if (timer_q == TW'(T_TIMEOUT - 1)) begin
                    timer_d  = '0;
                    estado_d = TIMEOUT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            REGISTRA: begin
                estado_d = COMPARA;
            end

            COMPARA: begin
                timer_d = '0;
                if (!acertou) begin
                    estado_d = PERDEU;
                end else if (endereco_q != rodada_q) begin
                    estado_d = PROX_JOGADA;
                end else if (rodada_q == ultima_rodada) begin
                    estado_d = GANHOU;
                end else begin
                    estado_d = PROX_RODADA;
                end
            end

            PROX_JOGADA: begin
                if (timer_q == TW'(T_PAUSA - 1)) begin
                    timer_d    = '0;
                    endereco_d = endereco_q + RW'(1);
                    estado_d   = ESPERA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            PROX_RODADA: begin
                if (timer_q == TW'(T_PAUSA - 1)) begin
                    timer_d    = '0;
                    rodada_d   = rodada_q + RW'(1);
                    endereco_d = '0;
                    estado_d   = MOSTRA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            default: begin
                estado_d = INICIAL;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q     <= INICIAL;
            rodada_q     <= '0;
            endereco_q   <= '0;
            timer_q      <= '0;
            banco_q      <= '0;
            nivel_q      <= 1'b0;
            jogada_q     <= '0;
            botoes_q     <= '0;
            botoes_ant_q <= '0;
        end else begin
            estado_q     <= estado_d;
            rodada_q     <= rodada_d;
            endereco_q   <= endereco_d;
            timer_q      <= timer_d;
            banco_q      <= banco_d;
            nivel_q      <= nivel_d;
            jogada_q     <= jogada_d;
            botoes_q     <= botoes_d;
            botoes_ant_q <= botoes_ant_d;
        end
    end

    // Only ESPERA echoes the live buttons; everything else decodes registered state.
    assign bus.leds        = (estado_q == ESPERA) ? bus.botoes
                           : (estado_q == MOSTRA) ? palavra_seq
                           : '0;
    assign bus.ganhou      = (estado_q == GANHOU);
    assign bus.perdeu      = (estado_q == PERDEU);
    assign bus.timeout     = (estado_q == TIMEOUT);
    assign bus.pronto      = (estado_q == GANHOU) || (estado_q == PERDEU) || (estado_q == TIMEOUT);
    assign bus.db_estado   = estado_q;
    assign bus.db_rodada   = rodada_q;
    assign bus.db_endereco = endereco_q;

endmodule

// File: tb/tb_jogo_memoria_parametrizado.sv
// Directed bench for the memory game: full win, wrong press, multi-button,
// held button, timeout and its boundary, bank select and mid-game reset.
module tb_jogo_memoria_parametrizado;
    import jogo_memoria_pkg::*;

    localparam int N_BOTOES  = 4;
    localparam int PROF      = 16;
    localparam int N_BANCOS  = 2;
    localparam int T_LED     = 5;
    localparam int T_PAUSA   = 3;
    localparam int T_TIMEOUT = 80;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    jogo_memoria_parametrizado_if #(
        .N_BOTOES (N_BOTOES),
        .PROF     (PROF),
        .N_BANCOS (N_BANCOS)
    ) bus ();

    jogo_memoria_parametrizado #(
        .N_BOTOES  (N_BOTOES),
        .PROF      (PROF),
        .N_BANCOS  (N_BANCOS),
        .T_LED     (T_LED),
        .T_PAUSA   (T_PAUSA),
        .T_TIMEOUT (T_TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Bank 0 content for N_BOTOES=4, written out by hand.
    logic [3:0] seq_b0 [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                               4'b0001, 4'b0010, 4'b0100, 4'b1000};

    int n_total = 0;
    int n_ok    = 0;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_ok++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic espera_estado(input estado_t alvo, input int limite, input string tag);
        int n = 0;
        while (bus.db_estado !== alvo && n < limite) begin
            tick();
            n++;
        end
        verifica(tag, bus.db_estado, alvo);
    endtask

    task automatic iniciar(input logic mem);
        bus.memoria = mem;
        bus.nivel   = 1'b0;
        bus.jogar   = 1'b1;
        tick();
        bus.jogar   = 1'b0;
        verifica("prepara", bus.db_estado, PREPARA);
    endtask

    // Playback of round r from bank 0: every step's LED word, address and duration.
    task automatic mostra_rodada(input int r);
        for (int i = 0; i <= r; i++) begin
            int n = 0;
            espera_estado(MOSTRA, 50, $sformatf("mostra r%0d s%0d", r, i));
            verifica($sformatf("led r%0d s%0d", r, i), bus.leds, seq_b0[i]);
            verifica($sformatf("endereco r%0d s%0d", r, i), bus.db_endereco, i);
            while (bus.db_estado === MOSTRA && n < 50) begin
                tick();
                n++;
            end
            verifica($sformatf("t_led r%0d s%0d", r, i), n, T_LED);
        end
        espera_estado(ESPERA, 50, $sformatf("espera r%0d", r));
    endtask

    // One press held for one cycle; checks echo and the k+1/k+2/k+3 pipeline.
    task automatic pressiona(input logic [3:0] val, input estado_t resultado, input string tag);
        bus.botoes = val;
        #1;
        verifica({tag, " eco"}, bus.leds, val);
        tick();
        bus.botoes = '0;
        tick();
        verifica({tag, " registra"}, bus.db_estado, REGISTRA);
        tick();
        verifica({tag, " compara"}, bus.db_estado, COMPARA);
        tick();
        verifica({tag, " resultado"}, bus.db_estado, resultado);
        $display("jogada %s botoes=%b estado=%0d rodada=%0d", tag, val, bus.db_estado, bus.db_rodada);
    endtask

    task automatic joga_rodada(input int r);
        mostra_rodada(r);
        for (int i = 0; i <= r; i++) begin
            estado_t res;
            res = (i < r) ? PROX_JOGADA : ((r == 7) ? GANHOU : PROX_RODADA);
            espera_estado(ESPERA, 50, $sformatf("espera r%0d s%0d", r, i));
            pressiona(seq_b0[i], res, $sformatf("r%0d s%0d", r, i));
        end
    endtask

    initial begin
        int n;
        int n_prepara;

        bus.jogar   = 1'b0;
        bus.botoes  = '0;
        bus.nivel   = 1'b0;
        bus.memoria = '0;
        reset       = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        repeat (20) tick();
        verifica("reset leds",     bus.leds,        0);
        verifica("reset ganhou",   bus.ganhou,      0);
        verifica("reset perdeu",   bus.perdeu,      0);
        verifica("reset timeout",  bus.timeout,     0);
        verifica("reset pronto",   bus.pronto,      0);
        verifica("reset estado",   bus.db_estado,   INICIAL);
        verifica("reset rodada",   bus.db_rodada,   0);
        verifica("reset endereco", bus.db_endereco, 0);

        // Full win, bank 0, level 0: eight rounds.
        iniciar(1'b0);
        for (int r = 0; r < 8; r++) joga_rodada(r);
        verifica("win ganhou", bus.ganhou,    1);
        verifica("win pronto", bus.pronto,    1);
        verifica("win perdeu", bus.perdeu,    0);
        verifica("win rodada", bus.db_rodada, 7);
        repeat (5) tick();
        verifica("win held", bus.ganhou, 1);

        // Bank 1 from GANHOU; memoria change mid-game ignored; two buttons lose.
        iniciar(1'b1);
        verifica("b1 ganhou clr", bus.ganhou, 0);
        espera_estado(MOSTRA, 10, "b1 mostra");
        verifica("b1 led0", bus.leds, 4'b0010);
        bus.memoria = 1'b0;
        tick();
        tick();
        verifica("b1 led0 kept", bus.leds, 4'b0010);
        espera_estado(ESPERA, 50, "b1 espera");
        pressiona(4'b0011, PERDEU, "b1 dois botoes");
        verifica("b1 perdeu", bus.perdeu, 1);
        verifica("b1 pronto", bus.pronto, 1);

        // Held button counted once, then wrong third press in round 3.
        iniciar(1'b0);
        joga_rodada(0);
        mostra_rodada(1);
        bus.botoes = 4'b0001;
        repeat (4) tick();
        verifica("hold aceito", bus.db_estado, PROX_JOGADA);
        repeat (46) tick();
        verifica("hold estado",   bus.db_estado,   ESPERA);
        verifica("hold endereco", bus.db_endereco, 1);
        bus.botoes = '0;
        tick();
        pressiona(4'b0010, PROX_RODADA, "hold s1");
        mostra_rodada(2);
        pressiona(4'b0001, PROX_JOGADA, "r2 s0");
        espera_estado(ESPERA, 50, "r2 espera s1");
        pressiona(4'b0010, PROX_JOGADA, "r2 s1");
        espera_estado(ESPERA, 50, "r2 espera s2");
        pressiona(4'b1000, PERDEU, "r2 errado");
        verifica("errado perdeu", bus.perdeu, 1);
        verifica("errado ganhou", bus.ganhou, 0);

        // jogar held high restarts once; then idle round 2 times out.
        n_prepara   = 0;
        bus.memoria = 1'b0;
        bus.jogar   = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.db_estado === PREPARA) n_prepara++;
        end
        bus.jogar = 1'b0;
        verifica("jogar uma vez", n_prepara, 1);
        espera_estado(ESPERA, 50, "to espera r0");
        pressiona(4'b0001, PROX_RODADA, "to r0");
        mostra_rodada(1);
        n = 0;
        while (bus.db_estado === ESPERA && n < 200) begin
            tick();
            n++;
        end
        verifica("t_timeout",      n,           T_TIMEOUT);
        verifica("timeout flag",   bus.timeout, 1);
        verifica("timeout pronto", bus.pronto,  1);
        verifica("timeout perdeu", bus.perdeu,  0);

        // Press landing on the expiry cycle wins over timeout.
        iniciar(1'b0);
        joga_rodada(0);
        mostra_rodada(1);
        repeat (T_TIMEOUT - 2) tick();
        pressiona(4'b0001, PROX_JOGADA, "expira s0");
        espera_estado(ESPERA, 50, "expira espera s1");
        pressiona(4'b0010, PROX_RODADA, "expira s1");
        joga_rodada(2);

        // Asynchronous reset during round-4 playback.
        espera_estado(MOSTRA, 50, "r3 mostra");
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        verifica("async estado", bus.db_estado, INICIAL);
        verifica("async leds",   bus.leds,      0);
        verifica("async rodada", bus.db_rodada, 0);
        verifica("async pronto", bus.pronto,    0);
        tick();
        reset = 1'b1;
        repeat (3) tick();
        verifica("pos reset estado", bus.db_estado, INICIAL);

        $display("%0d/%0d checks passed", n_ok, n_total);
        $finish;
    end

endmodule
